// File: rtl/tree_loader.sv
// Host-side programming engine for the decision-tree classifier: unpacks a framed,
// XOR-checksummed byte stream into single-cycle node writes and gates classifier start.
module tree_loader #(
    parameter int MAX_NODES      = 64,
    parameter int ADDR_WIDTH     = $clog2(MAX_NODES),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  sw_we,
    output logic [ADDR_WIDTH-1:0] sw_addr,
    output logic                  sw_data_is_leaf,
    output logic                  sw_data_less_than,
    output logic [7:0]            sw_data_threshold,
    output logic [ADDR_WIDTH-1:0] sw_data_left_idx,
    output logic [ADDR_WIDTH-1:0] sw_data_right_idx,
    output logic [1:0]            sw_data_action,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  engine_hold
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0] MaxN = 9'(MAX_NODES);

    typedef enum logic [2:0] {StIdle, StCount, StRec, StWrite, StCsum} state_t;

    state_t                r_state;
    logic                  r_s_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_leaf;
    logic                  r_lt;
    logic [7:0]            r_thr_out;
    logic [ADDR_WIDTH-1:0] r_left;
    logic [ADDR_WIDTH-1:0] r_right;
    logic [1:0]            r_action;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_hold;
    logic [7:0]            r_count;
    logic [7:0]            r_xor;
    logic [1:0]            r_b;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [7:0]            r_b0;
    logic [7:0]            r_thr;
    logic [7:0]            r_b2;
    logic [TW-1:0]         r_tmo;

    logic w_accept;
    logic w_bad_count;
    logic w_rec_ok;
    logic w_last;
    logic w_tmo;
    logic w_err;

    assign w_accept    = s_valid && r_s_ready;
    assign w_bad_count = (s_data == 8'd0) || ({1'b0, s_data} > MaxN);
    // Leaves carry don't-care child indices, so only internal nodes are range-checked.
    assign w_rec_ok    = (r_b0[5:2] == 4'd0) &&
                         (r_b0[7] || ((r_b2 < r_count) && (s_data < r_count)));
    assign w_last      = (8'(r_idx) == (r_count - 8'd1));
    assign w_tmo       = (r_state != StIdle) && !w_accept &&
                         (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_err       = w_tmo ||
                         (w_accept && (((r_state == StCount) && w_bad_count) ||
                                       ((r_state == StRec) && (r_b == 2'd3) && !w_rec_ok) ||
                                       ((r_state == StCsum) && (s_data != r_xor))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_s_ready <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_leaf    <= 1'b0;
            r_lt      <= 1'b0;
            r_thr_out <= 8'd0;
            r_left    <= '0;
            r_right   <= '0;
            r_action  <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_hold    <= 1'b1;
            r_count   <= 8'd0;
            r_xor     <= 8'd0;
            r_b       <= 2'd0;
            r_idx     <= '0;
            r_b0      <= 8'd0;
            r_thr     <= 8'd0;
            r_b2      <= 8'd0;
            r_tmo     <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (r_state == StIdle || w_accept) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end

            if (w_err) begin
                // Nodes already written stay in the classifier; hold keeps start gated.
                r_state   <= StIdle;
                r_s_ready <= 1'b1;
                r_err     <= 1'b1;
                r_busy    <= 1'b0;
                r_hold    <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_s_ready <= 1'b1;
                        if (w_accept && s_data == 8'hA5) begin
                            r_state <= StCount;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                            r_hold  <= 1'b1;
                            r_xor   <= 8'd0;
                            r_idx   <= '0;
                        end
                    end
                    StCount: begin
                        if (w_accept) begin
                            r_count <= s_data;
                            r_xor   <= s_data;
                            r_b     <= 2'd0;
                            r_state <= StRec;
                        end
                    end
                    StRec: begin
                        if (w_accept) begin
                            r_xor <= r_xor ^ s_data;
                            r_b   <= r_b + 2'd1;
                            unique case (r_b)
                                2'd0: r_b0 <= s_data;
                                2'd1: r_thr <= s_data;
                                2'd2: r_b2 <= s_data;
                                default: begin
                                    r_state   <= StWrite;
                                    r_s_ready <= 1'b0;
                                    r_we      <= 1'b1;
                                    r_addr    <= r_idx;
                                    r_leaf    <= r_b0[7];
                                    r_lt      <= r_b0[6];
                                    r_action  <= r_b0[1:0];
                                    r_thr_out <= r_thr;
                                    r_left    <= r_b2[ADDR_WIDTH-1:0];
                                    r_right   <= s_data[ADDR_WIDTH-1:0];
                                end
                            endcase
                        end
                    end
                    StWrite: begin
                        r_s_ready <= 1'b1;
                        r_idx     <= r_idx + 1'b1;
                        r_b       <= 2'd0;
                        r_state   <= w_last ? StCsum : StRec;
                    end
                    StCsum: begin
                        if (w_accept) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_hold  <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign s_ready           = r_s_ready;
    assign sw_we             = r_we;
    assign sw_addr           = r_addr;
    assign sw_data_is_leaf   = r_leaf;
    assign sw_data_less_than = r_lt;
    assign sw_data_threshold = r_thr_out;
    assign sw_data_left_idx  = r_left;
    assign sw_data_right_idx = r_right;
    assign sw_data_action    = r_action;
    assign load_busy         = r_busy;
    assign load_done         = r_done;
    assign load_error        = r_err;
    assign engine_hold       = r_hold;

endmodule

// File: tb/tb_tree_loader.sv
// Scoreboard bench for tree_loader: a frame-level model predicts node writes and
// frame outcomes; a negedge monitor checks everything the DUT presents.
module tb_tree_loader;

    localparam int MaxNodes = 64;
    localparam int Aw       = 6;
    localparam int Tmo      = 1024;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int    kind;   // 0 status, 1 expired wait, 2 reset values
        string name;
        logic  rdy;
        logic  busy;
        logic  err;
        logic  hold;
        int    dones;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          sw_we;
    logic [Aw-1:0] sw_addr;
    logic          sw_data_is_leaf;
    logic          sw_data_less_than;
    logic [7:0]    sw_data_threshold;
    logic [Aw-1:0] sw_data_left_idx;
    logic [Aw-1:0] sw_data_right_idx;
    logic [1:0]    sw_data_action;
    logic          load_busy;
    logic          load_done;
    logic          load_error;
    logic          engine_hold;

    logic [29:0] wr_q[$];
    chk_t        chk_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          done_seen = 0;
    int          exp_dones = 0;

    tree_loader #(
        .MAX_NODES     (MaxNodes),
        .ADDR_WIDTH    (Aw),
        .TIMEOUT_CYCLES(Tmo)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .sw_we            (sw_we),
        .sw_addr          (sw_addr),
        .sw_data_is_leaf  (sw_data_is_leaf),
        .sw_data_less_than(sw_data_less_than),
        .sw_data_threshold(sw_data_threshold),
        .sw_data_left_idx (sw_data_left_idx),
        .sw_data_right_idx(sw_data_right_idx),
        .sw_data_action   (sw_data_action),
        .load_busy        (load_busy),
        .load_done        (load_done),
        .load_error       (load_error),
        .engine_hold      (engine_hold)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: the only process that makes comparisons.
    always @(negedge clk) begin
        logic [29:0] w;
        chk_t c;
        if (rst_n && sw_we) begin
            cmp("s_ready_low_during_write", 32'(s_ready), 32'd0);
            if (wr_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got write to addr %0d, expected none", sw_addr);
            end else begin
                w = wr_q.pop_front();
                cmp("node_write", 32'({sw_addr, sw_data_is_leaf, sw_data_less_than,
                    sw_data_threshold, sw_data_left_idx, sw_data_right_idx, sw_data_action}),
                    32'(w));
            end
        end
        if (rst_n && load_done) begin
            done_seen++;
            cmp("busy_hold_err_at_done", 32'({load_busy, engine_hold, load_error}), 32'd0);
        end
        if (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            if (c.kind == 1) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: got no handshake in bound, expected byte accepted", c.name);
            end else begin
                cmp({c.name, "_status"}, 32'({s_ready, load_busy, load_error, engine_hold}),
                    32'({c.rdy, c.busy, c.err, c.hold}));
                cmp({c.name, "_done_count"}, 32'(done_seen), 32'(c.dones));
                if (c.kind == 2) begin
                    cmp({c.name, "_sw_outputs"}, 32'({sw_we, sw_addr, sw_data_is_leaf,
                        sw_data_less_than, sw_data_threshold, sw_data_left_idx,
                        sw_data_right_idx, sw_data_action, load_done}), 32'd0);
                end else begin
                    cmp({c.name, "_pending_writes"}, 32'(wr_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic push_chk(input int kind, input string nm, input logic rdy, input logic busy,
                            input logic err, input logic hold);
        chk_t c;
        c.kind = kind; c.name = nm; c.rdy = rdy; c.busy = busy;
        c.err = err; c.hold = hold; c.dones = exp_dones;
        chk_q.push_back(c);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_data  = b;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) push_chk(1, "byte_handshake", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset_check(input string nm);
        rst_n = 1'b0;
        #1;
        push_chk(2, nm, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_chk(0, {nm, "_released"}, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // fb holds count, records and checksum (no SYNC). Bytes after the first offending one are
    // not sent, so stray 0xA5 values in a corrupt frame cannot start an unplanned frame.
    task automatic run_frame(input string nm, input bq_t fb, input int maxgap,
                             input int stall_at, input int stall_len, input int reset_after);
        bit ok;
        bit err;
        bit done;
        int n;
        int gap;
        logic [7:0] b0;
        logic [7:0] x;
        err  = 1'b0;
        done = 1'b0;
        send_byte(8'hA5, $urandom_range(0, maxgap), ok);
        n = int'(fb[0]);
        for (int k = 0; k < fb.size() && !err && !done; k++) begin
            gap = (k == stall_at) ? stall_len : int'($urandom_range(0, maxgap));
            if (gap >= Tmo) begin
                s_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                err = 1'b1;
            end else if (k == 0) begin
                send_byte(fb[k], gap, ok);
                if (n == 0 || n > MaxNodes) err = 1'b1;
            end else if (k <= 4 * n) begin
                if ((k - 1) % 4 == 3) begin
                    b0 = fb[k - 3];
                    if (b0[5:2] != 4'd0 ||
                        (!b0[7] && (int'(fb[k - 1]) >= n || int'(fb[k]) >= n))) begin
                        err = 1'b1;
                    end else begin
                        wr_q.push_back({6'((k - 1) / 4), b0[7], b0[6], fb[k - 2],
                                        fb[k - 1][5:0], fb[k][5:0], b0[1:0]});
                    end
                end
                send_byte(fb[k], gap, ok);
                if ((k - 1) / 4 == reset_after && (k - 1) % 4 == 3) begin
                    @(negedge clk);
                    @(posedge clk);
                    #1;
                    do_reset_check({nm, "_midreset"});
                    return;
                end
            end else begin
                x = 8'd0;
                for (int j = 0; j < k; j++) x ^= fb[j];
                send_byte(fb[k], gap, ok);
                if (fb[k] == x) done = 1'b1;
                else err = 1'b1;
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        if (done) exp_dones++;
        push_chk(0, nm, 1'b1, 1'b0, !done, !done);
    endtask

    function automatic bq_t mk_frame(input int n, input int bad);
        bq_t q;
        logic [7:0] b0, b1, b2, b3, x;
        int pick;
        pick = $urandom_range(0, n - 1);
        q.push_back(8'(n));
        for (int r = 0; r < n; r++) begin
            b0 = {1'($urandom), 1'($urandom), 4'd0, 2'($urandom)};
            b1 = 8'($urandom);
            if (b0[7]) begin
                b2 = 8'($urandom);
                b3 = 8'($urandom);
            end else begin
                b2 = 8'($urandom_range(0, n - 1));
                b3 = 8'($urandom_range(0, n - 1));
            end
            if (r == pick && bad == 2) b0[5:2] = 4'($urandom_range(1, 15));
            if (r == pick && bad == 3) begin
                b0[7] = 1'b0;
                b2    = 8'($urandom_range(n, 255));
            end
            q.push_back(b0); q.push_back(b1); q.push_back(b2); q.push_back(b3);
        end
        x = 8'd0;
        foreach (q[i]) x ^= q[i];
        if (bad == 1) x ^= 8'(1 << $urandom_range(0, 7));
        q.push_back(x);
        return q;
    endfunction

    initial begin
        bq_t f1;
        bq_t fx;
        bit ok;
        logic [7:0] g;
        f1 = '{8'h03, 8'h40, 8'h80, 8'h01, 8'h02, 8'h81, 8'h00, 8'h00, 8'h00,
               8'h82, 8'h00, 8'h00, 8'h00, 8'hC3};
        #1;
        push_chk(2, "reset", 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_chk(0, "after_reset", 1'b1, 1'b0, 1'b0, 1'b1);

        run_frame("good3", f1, 0, -1, 0, -1);
        fx = f1; fx[13] = 8'hC2;
        run_frame("bad_csum", fx, 0, -1, 0, -1);
        run_frame("good_after_bad", f1, 0, -1, 0, -1);
        fx = '{8'h00};
        run_frame("count_zero", fx, 0, -1, 0, -1);
        fx = '{8'h41};
        run_frame("count_65", fx, 0, -1, 0, -1);
        fx = f1; fx[3] = 8'h05;
        run_frame("bad_left_idx", fx, 0, -1, 0, -1);
        fx = f1; fx[1] = 8'h44;
        run_frame("reserved_bit", fx, 0, -1, 0, -1);
        run_frame("stall_tmo_minus1", f1, 0, 3, Tmo - 1, -1);
        run_frame("stall_tmo", f1, 0, 3, Tmo, -1);
        send_byte(8'h11, 0, ok);
        send_byte(8'h22, 0, ok);
        run_frame("garbage_then_good", f1, 0, -1, 0, -1);
        run_frame("backpressure", f1, 3, -1, 0, -1);
        run_frame("reset_mid_frame", mk_frame(3, 0), 1, -1, 0, 1);
        run_frame("good_after_reset", f1, 0, -1, 0, -1);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, $urandom_range(0, 2), ok);
            end
            fx = mk_frame($urandom_range(1, 8),
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
            run_frame("random", fx, $urandom_range(0, 3), -1, 0, -1);
        end
        run_frame("full_capacity", mk_frame(MaxNodes, 0), 0, -1, 0, -1);

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
